// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle RV32I control FSM with variable-latency memory handshake and illegal-opcode trap.
module multicycle_controller #(
  parameter int ALUC_W      = 3,
  parameter bit TRAP_STICKY = 1'b1
`ifdef RETIRE_CNT_EN
  ,
  parameter int RET_W       = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        op,
  input  logic [2:0]        func3,
  input  logic [6:0]        func7,
  input  logic              zero,
  input  logic              lt,
  input  logic              mem_ready,
  output logic              PCWrite,
  output logic              IRWrite,
  output logic              RegWrite,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              AdrSrc,
  output logic [1:0]        ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        ResultSrc,
  output logic [2:0]        ImmSrc,
  output logic [ALUC_W-1:0] ALUControl,
  output logic              illegal,
  output logic [3:0]        state_o
`ifdef RETIRE_CNT_EN
  ,
  output logic [RET_W-1:0]  retired
`endif
);
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [ALUC_W-1:0] ALU_ADD = ALUC_W'(3'b000);
  localparam logic [ALUC_W-1:0] ALU_SUB = ALUC_W'(3'b001);
  localparam logic [ALUC_W-1:0] ALU_AND = ALUC_W'(3'b010);
  localparam logic [ALUC_W-1:0] ALU_OR  = ALUC_W'(3'b011);
  localparam logic [ALUC_W-1:0] ALU_XOR = ALUC_W'(3'b100);
  localparam logic [ALUC_W-1:0] ALU_SLT = ALUC_W'(3'b101);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXR, EXI,
    ALUWB, BRANCH, JAL, JALR1, JALR2, LUI, TRAP
  } state_t;

  state_t state, next;
  logic r_ok, i_ok, b_ok, b_taken;
  logic [ALUC_W-1:0] r_alu, i_alu, b_alu;

  assign b_ok    = ~func3[1];
  assign b_taken = func3[2] ? (lt ^ func3[0]) : (zero ^ func3[0]);
  assign b_alu   = func3[2] ? ALU_SLT : ALU_SUB;
  assign state_o = state;

  always_comb begin
    r_ok  = 1'b1;
    r_alu = ALU_ADD;
    i_ok  = 1'b1;
    i_alu = ALU_ADD;
    case ({func7, func3})
      {7'b0000000, 3'b000}: r_alu = ALU_ADD;
      {7'b0100000, 3'b000}: r_alu = ALU_SUB;
      {7'b0000000, 3'b111}: r_alu = ALU_AND;
      {7'b0000000, 3'b110}: r_alu = ALU_OR;
      {7'b0000000, 3'b010}: r_alu = ALU_SLT;
      default:              r_ok  = 1'b0;
    endcase
    case (func3)
      3'b000:  i_alu = ALU_ADD;
      3'b100:  i_alu = ALU_XOR;
      3'b110:  i_alu = ALU_OR;
      3'b010:  i_alu = ALU_SLT;
      default: i_ok  = 1'b0;
    endcase
  end

  always_comb begin
    next = state;
    case (state)
      FETCH:  next = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next = MEMADR;
          OP_R:         next = EXR;
          OP_I:         next = EXI;
          OP_B:         next = BRANCH;
          OP_JAL:       next = JAL;
          OP_JALR:      next = JALR1;
          OP_LUI:       next = LUI;
          default:      next = TRAP;
        endcase
      end
      MEMADR: next = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  next = mem_ready ? MEMWB : MEMRD;
      MEMWB:  next = FETCH;
      MEMWR:  next = mem_ready ? FETCH : MEMWR;
      EXR:    next = r_ok ? ALUWB : TRAP;
      EXI:    next = i_ok ? ALUWB : TRAP;
      ALUWB:  next = FETCH;
      BRANCH: next = b_ok ? FETCH : TRAP;
      JAL:    next = ALUWB;
      JALR1:  next = JALR2;
      JALR2:  next = ALUWB;
      LUI:    next = FETCH;
      TRAP:   next = TRAP_STICKY ? TRAP : FETCH;
      default: next = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FETCH;
`ifdef RETIRE_CNT_EN
      retired <= '0;
`endif
    end else begin
      state <= next;
`ifdef RETIRE_CNT_EN
      if (next == FETCH && state != FETCH && state != TRAP) retired <= retired + RET_W'(1);
`endif
    end
  end

  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ImmSrc     = 3'b000;
    ALUControl = ALU_ADD;
    illegal    = 1'b0;
    case (state)
      FETCH: begin
        MemRead   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_JAL) ? 3'b011 : 3'b010;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_SW) ? 3'b001 : 3'b000;
      end
      MEMRD: begin
        MemRead = 1'b1;
        AdrSrc  = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
      end
      EXR: begin
        ALUSrcA    = 2'b10;
        ALUControl = r_alu;
      end
      EXI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = i_alu;
      end
      ALUWB: RegWrite = 1'b1;
      BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = b_ok ? b_alu : ALU_ADD;
        PCWrite    = b_ok & b_taken;
      end
      JAL, JALR2: begin
        PCWrite = 1'b1;
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
      end
      JALR1: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      LUI: begin
        ImmSrc    = 3'b100;
        ResultSrc = 2'b11;
        RegWrite  = 1'b1;
      end
      TRAP: illegal = 1'b1;
      default: illegal = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized and directed checks of the multicycle controller against a per-instruction phase model.
module tb_multicycle_controller;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, LUI = 7'b0110111;
  localparam logic [6:0] BAD = 7'b1111111;

  typedef struct packed {
    logic pcw, irw, rw, mr, mw, adr;
    logic [1:0] a, b, rs;
    logic [2:0] imm, alu;
    logic ill;
  } ctrl_t;
  typedef struct packed {ctrl_t c; logic wt; logic fch;} ph_t;

  logic clk = 1'b0, rst = 1'b1;
  logic [6:0] op = '0, func7 = '0;
  logic [2:0] func3 = '0;
  logic zero = 1'b0, lt = 1'b0, mem_ready = 1'b0;
  logic PCWrite, IRWrite, RegWrite, MemRead, MemWrite, AdrSrc, illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0] ImmSrc, ALUControl;
  logic [3:0] state_o;
  logic n_pcw, n_irw, n_rw, n_mr, n_mw, n_adr, n_ill;
  logic [1:0] n_a, n_b, n_rs;
  logic [2:0] n_imm, n_alu;
  logic [3:0] n_state;
`ifdef RETIRE_CNT_EN
  logic [31:0] retired, n_retired;
`endif

  int checks = 0, errors = 0, retired_model = 0;
  ph_t q[$];

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7), .zero(zero), .lt(lt),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .illegal(illegal), .state_o(state_o)
`ifdef RETIRE_CNT_EN
    , .retired(retired)
`endif
  );

  multicycle_controller #(.TRAP_STICKY(1'b0)) dut0 (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7), .zero(zero), .lt(lt),
    .mem_ready(mem_ready), .PCWrite(n_pcw), .IRWrite(n_irw), .RegWrite(n_rw),
    .MemRead(n_mr), .MemWrite(n_mw), .AdrSrc(n_adr), .ALUSrcA(n_a),
    .ALUSrcB(n_b), .ResultSrc(n_rs), .ImmSrc(n_imm), .ALUControl(n_alu),
    .illegal(n_ill), .state_o(n_state)
`ifdef RETIRE_CNT_EN
    , .retired(n_retired)
`endif
  );

  function automatic ctrl_t act();
    return {PCWrite, IRWrite, RegWrite, MemRead, MemWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, illegal};
  endfunction

  function automatic ctrl_t n_act();
    return {n_pcw, n_irw, n_rw, n_mr, n_mw, n_adr, n_a, n_b, n_rs, n_imm, n_alu, n_ill};
  endfunction

  function automatic ctrl_t mk(input int pcw, irw, rw, mr, mw, adr, a, b, rs, imm, alu, ill);
    return {pcw[0], irw[0], rw[0], mr[0], mw[0], adr[0], a[1:0], b[1:0], rs[1:0], imm[2:0], alu[2:0], ill[0]};
  endfunction

  function automatic ctrl_t f_ctrl(input int r);
    return mk(r, r, 0, 1, 0, 0, 0, 2, 2, 0, 0, 0);
  endfunction

  function automatic ctrl_t trap_c();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endfunction

  function automatic ctrl_t wb_c();
    return mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  // Cycles per instruction with memory always ready
  function automatic int lat(input logic [6:0] o);
    case (o)
      LW, JALR: return 5;
      SW, RT, IT, JAL: return 4;
      BR, LUI: return 3;
      default: return 0;
    endcase
  endfunction

  task automatic push(input ctrl_t c, input logic wt);
    q.push_back({c, wt, 1'b0});
  endtask

  // Expected per-phase control words of one instruction, from FETCH to its last phase
  task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7, input logic z, l);
    logic ok, tk;
    int alu;
    q.delete();
    q.push_back({f_ctrl(0), 1'b1, 1'b1});
    push(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, (o == JAL) ? 3 : 2, 0, 0), 1'b0);
    ok = 1'b1;
    tk = 1'b0;
    alu = 0;
    case (o)
      LW: begin
        push(mk(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0), 1'b0);
        push(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0), 1'b1);
        push(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0), 1'b0);
      end
      SW: begin
        push(mk(0, 0, 0, 0, 0, 0, 2, 1, 0, 1, 0, 0), 1'b0);
        push(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0), 1'b1);
      end
      RT: begin
        if (f7 == 7'h00 && f3 == 3'd0) alu = 0;
        else if (f7 == 7'h20 && f3 == 3'd0) alu = 1;
        else if (f7 == 7'h00 && f3 == 3'd7) alu = 2;
        else if (f7 == 7'h00 && f3 == 3'd6) alu = 3;
        else if (f7 == 7'h00 && f3 == 3'd2) alu = 5;
        else ok = 1'b0;
        push(mk(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, alu, 0), 1'b0);
        push(ok ? wb_c() : trap_c(), 1'b0);
      end
      IT: begin
        if (f3 == 3'd0) alu = 0;
        else if (f3 == 3'd4) alu = 4;
        else if (f3 == 3'd6) alu = 3;
        else if (f3 == 3'd2) alu = 5;
        else ok = 1'b0;
        push(mk(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, alu, 0), 1'b0);
        push(ok ? wb_c() : trap_c(), 1'b0);
      end
      BR: begin
        if (f3 == 3'd0) begin alu = 1; tk = z; end
        else if (f3 == 3'd1) begin alu = 1; tk = !z; end
        else if (f3 == 3'd4) begin alu = 5; tk = l; end
        else if (f3 == 3'd5) begin alu = 5; tk = !l; end
        else ok = 1'b0;
        push(mk(int'(tk), 0, 0, 0, 0, 0, 2, 0, 0, 0, alu, 0), 1'b0);
        if (!ok) push(trap_c(), 1'b0);
      end
      JAL: begin
        push(mk(1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0), 1'b0);
        push(wb_c(), 1'b0);
      end
      JALR: begin
        push(mk(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0), 1'b0);
        push(mk(1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0), 1'b0);
        push(wb_c(), 1'b0);
      end
      LUI: push(mk(0, 0, 1, 0, 0, 0, 0, 0, 3, 4, 0, 0), 1'b0);
      default: push(trap_c(), 1'b0);
    endcase
  endtask

  // Runs one instruction from FETCH; pct = chance (%) of mem_ready low, hold = forced waits in MEMRD/MEMWR
  task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7, input logic z, l,
                     input int pct, input int hold, output bit trapped);
    ctrl_t e;
    int cyc = 0, st = 0;
    build(o, f3, f7, z, l);
    trapped = q[$].c.ill;
    op = o; func3 = f3; func7 = f7; zero = z; lt = l;
    while (q.size() > 0 && cyc < 200) begin
      if (q[0].wt && !q[0].fch && hold > 0) begin
        mem_ready = 1'b0;
        hold--;
      end else mem_ready = ($urandom_range(99) >= pct);
      @(negedge clk);
      e = q[0].c;
      if (q[0].fch) begin e.pcw = mem_ready; e.irw = mem_ready; end
      checks++;
      if (act() !== e) begin
        errors++;
        $display("FAIL ctrl op=%b f3=%b f7=%b cycle %0d got %b expected %b", o, f3, f7, cyc, act(), e);
      end
      cyc++;
      if (q[0].wt && !mem_ready) st++;
      else void'(q.pop_front());
      @(posedge clk); #1;
    end
    if (!trapped) begin
      checks++;
      if (cyc !== lat(o) + st) begin
        errors++;
        $display("FAIL latency op=%b got %0d cycles expected %0d", o, cyc, lat(o) + st);
      end
      retired_model++;
    end
  endtask

  task automatic do_reset();
    mem_ready = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    retired_model = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    mem_ready = 1'b0;
    #2;
    checks++;
    if (act() !== f_ctrl(0)) begin errors++; $display("FAIL reset_ctrl got %b expected %b", act(), f_ctrl(0)); end
    mem_ready = 1'b1;
    #1;
    checks += 2;
    if (act() !== f_ctrl(1)) begin errors++; $display("FAIL reset_ready got %b expected %b", act(), f_ctrl(1)); end
    if (n_act() !== f_ctrl(1)) begin errors++; $display("FAIL reset_ready_nonsticky got %b expected %b", n_act(), f_ctrl(1)); end
`ifdef RETIRE_CNT_EN
    checks++;
    if (retired !== 32'd0) begin errors++; $display("FAIL reset_retired got %0d expected 0", retired); end
`endif
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    bit tr;
    run(RT, 3'd0, 7'h00, 1'b0, 1'b0, 0, 0, tr);
    run(LW, 3'd2, 7'h00, 1'b0, 1'b0, 0, 3, tr);
    run(SW, 3'd2, 7'h00, 1'b0, 1'b0, 0, 4, tr);
    run(BR, 3'd0, 7'h00, 1'b1, 1'b0, 0, 0, tr);
    run(BR, 3'd5, 7'h00, 1'b0, 1'b1, 0, 0, tr);
    run(JALR, 3'd0, 7'h00, 1'b0, 1'b0, 0, 0, tr);
    run(JAL, 3'd0, 7'h00, 1'b0, 1'b0, 0, 0, tr);
    run(LUI, 3'd0, 7'h00, 1'b0, 1'b0, 0, 0, tr);
  endtask

  task automatic test_trap();
    do_reset();
    op = BAD; func3 = 3'd0; func7 = 7'h00; mem_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    checks += 2;
    if (act() !== trap_c()) begin errors++; $display("FAIL trap_enter got %b expected %b", act(), trap_c()); end
    if (n_act() !== trap_c()) begin errors++; $display("FAIL trap_enter_nonsticky got %b expected %b", n_act(), trap_c()); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      mem_ready = 1'($urandom);
      @(negedge clk);
      checks++;
      if (act() !== trap_c()) begin errors++; $display("FAIL trap_hold cycle %0d got %b expected %b", i, act(), trap_c()); end
      if (i == 0) begin
        checks += 2;
        if (n_act() !== f_ctrl(int'(mem_ready))) begin
          errors++;
          $display("FAIL trap_pulse got %b expected %b", n_act(), f_ctrl(int'(mem_ready)));
        end
        if (state_o === n_state) begin errors++; $display("FAIL trap_states got %0d and %0d expected different", state_o, n_state); end
      end
    end
  endtask

  task automatic test_illegal_funct();
    bit tr;
    logic [16:0] cases [5] = '{{RT, 3'd1, 7'h00}, {RT, 3'd7, 7'h20}, {IT, 3'd1, 7'h00}, {BR, 3'd2, 7'h00}, {BR, 3'd7, 7'h00}};
    for (int i = 0; i < 5; i++) begin
      do_reset();
      run(cases[i][16:10], cases[i][9:7], cases[i][6:0], 1'b1, 1'b1, 0, 0, tr);
      @(negedge clk);
      checks += 2;
      if (!tr) begin errors++; $display("FAIL illegal_model case %0d got no trap expected trap", i); end
      if (act() !== trap_c()) begin errors++; $display("FAIL illegal_hold case %0d got %b expected %b", i, act(), trap_c()); end
      @(posedge clk); #1;
    end
    do_reset();
  endtask

  task automatic test_reset_abort();
    do_reset();
    op = SW; func3 = 3'd2; func7 = 7'h00; mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (!(MemWrite === 1'b1 && AdrSrc === 1'b1)) begin errors++; $display("FAIL abort_pre got MemWrite=%b AdrSrc=%b expected 1 1", MemWrite, AdrSrc); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (act() !== f_ctrl(0)) begin errors++; $display("FAIL abort_async got %b expected %b", act(), f_ctrl(0)); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (act() !== f_ctrl(0)) begin errors++; $display("FAIL abort_held got %b expected %b", act(), f_ctrl(0)); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    retired_model = 0;
  endtask

  task automatic test_back_to_back();
    bit tr;
    logic [9:0] rt_tab [5] = '{10'b0000000000, 10'b0100000000, 10'b0000000111, 10'b0000000110, 10'b0000000010};
    logic [2:0] it_tab [4] = '{3'd0, 3'd4, 3'd6, 3'd2};
    logic [2:0] br_tab [4] = '{3'd0, 3'd1, 3'd4, 3'd5};
    logic [6:0] ops [8] = '{LW, SW, RT, IT, BR, JAL, JALR, LUI};
    logic [6:0] o, f7;
    logic [2:0] f3;
    logic [9:0] rf;
    logic z, l;
    for (int i = 0; i < 80; i++) begin
      o = ops[$urandom_range(7)];
      f3 = 3'($urandom);
      f7 = 7'($urandom);
      z = 1'($urandom);
      l = 1'($urandom);
      if (o == RT) begin rf = rt_tab[$urandom_range(4)]; f7 = rf[9:3]; f3 = rf[2:0]; end
      if (o == IT) f3 = it_tab[$urandom_range(3)];
      if (o == BR) f3 = br_tab[$urandom_range(3)];
      run(o, f3, f7, z, l, 30, 0, tr);
    end
`ifdef RETIRE_CNT_EN
    checks++;
    if (retired !== 32'(retired_model)) begin errors++; $display("FAIL retired_stream got %0d expected %0d", retired, retired_model); end
`endif
  endtask

`ifdef RETIRE_CNT_EN
  task automatic test_retire();
    bit tr;
    do_reset();
    repeat (3) run(IT, 3'd0, 7'h00, 1'b0, 1'b0, 20, 0, tr);
    run(BAD, 3'd0, 7'h00, 1'b0, 1'b0, 0, 0, tr);
    @(negedge clk);
    checks++;
    if (retired !== 32'd3) begin errors++; $display("FAIL retired_addi got %0d expected 3", retired); end
    do_reset();
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_trap();
    test_illegal_funct();
    test_reset_abort();
`ifdef RETIRE_CNT_EN
    test_retire();
`endif
    test_directed();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got no finish expected finish");
    $fatal(1);
  end
endmodule
